// File: rtl/pulse_bcd_display.sv
// Pulse-rate display driver: sequential double-dabble binary-to-BCD conversion
// feeding a time-multiplexed 4-digit common-anode seven-segment display.
module pulse_bcd_display #(
  parameter int unsigned SCAN_DIV = 250000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic [15:0] value,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state, state_next;
  logic [15:0]   last_value;
  logic [31:0]   work;       // {bcd_work, bin}
  logic [31:0]   work_adj;
  logic          ovf_pend;
  logic [3:0]    iter;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Conversion FSM state register
  always_ff @(posedge CLK100MHZ) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Conversion FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value != last_value) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (iter == 4'd15) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Double-dabble add-3 step on each BCD nibble; nibbles never carry into each other
  always_comb begin
    work_adj = work;
    for (int unsigned i = 0; i < 4; i++) begin
      if (work[16 + 4*i +: 4] >= 4'd5)
        work_adj[16 + 4*i +: 4] = work[16 + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: load, 16 shift iterations, publish result
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      last_value <= '0;
      work       <= '0;
      ovf_pend   <= 1'b0;
      iter       <= '0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          last_value <= value;
          iter       <= '0;
          if (value > 16'd9999) begin
            work     <= {16'd0, 16'd9999};
            ovf_pend <= 1'b1;
          end else begin
            work     <= {16'd0, value};
            ovf_pend <= 1'b0;
          end
        end
        SHIFT: begin
          work <= work_adj << 1;
          iter <= iter + 4'd1;
        end
        DONE: begin
          bcd <= work[31:16];
          ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // Segment pattern for the digit currently selected, with leading-zero blanking
  always_comb begin
    digit = bcd[{idx, 2'b00} +: 4];
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (bcd[15:12] == 4'd0);
      2'd2:    blank = (bcd[15:8]  == 8'd0);
      2'd1:    blank = (bcd[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    blank    = blank && BLANK_LZ;
    seg_next = blank ? 7'b1111111 : seg_decode(digit);
  end

  // Digit scanner; outputs are registered from the current index, so each
  // digit appears one cycle after its index and still gets SCAN_DIV cycles
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= 4'b1111;
      seg      <= 7'b1111111;
      dp       <= 1'b1;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_next;
      dp  <= ~((idx == 2'd3) && ovf);
    end
  end

endmodule

// File: tb/tb_pulse_bcd_display.sv
// Directed self-checking bench for pulse_bcd_display with a short scan period.
module tb_pulse_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S6 = 7'b0000010,
                         S5 = 7'b0010010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;

  typedef struct packed {
    logic [15:0]     val;
    logic [15:0]     bcd;
    logic            ovf;
    logic [3:0][6:0] seg;   // seg[0] = units digit
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        busy;
  logic [15:0] bcd;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  vec_t vecs[10];

  pulse_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .CLK100MHZ(clk), .rst(rst), .value(value), .busy(busy), .bcd(bcd),
    .ovf(ovf), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_not_busy(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("conv_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input vec_t v);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin chk("seg_d0", {25'd0, seg}, {25'd0, v.seg[0]}); chk("dp_d0", {31'd0, dp}, 32'd1); end
        4'b1101: begin chk("seg_d1", {25'd0, seg}, {25'd0, v.seg[1]}); chk("dp_d1", {31'd0, dp}, 32'd1); end
        4'b1011: begin chk("seg_d2", {25'd0, seg}, {25'd0, v.seg[2]}); chk("dp_d2", {31'd0, dp}, 32'd1); end
        4'b0111: begin chk("seg_d3", {25'd0, seg}, {25'd0, v.seg[3]}); chk("dp_d3", {31'd0, dp}, {31'd0, ~v.ovf}); end
        default: chk("an_onehot", {28'd0, an}, 32'hE);
      endcase
    end
  endtask

  initial begin
    vecs[0] = '{16'd72,    16'h0072, 1'b0, {SB, SB, S7, S2}};
    vecs[1] = '{16'd1234,  16'h1234, 1'b0, {S1, S2, S3, S4}};
    vecs[2] = '{16'd1004,  16'h1004, 1'b0, {S1, S0, S0, S4}};
    vecs[3] = '{16'd12000, 16'h9999, 1'b1, {S9, S9, S9, S9}};
    vecs[4] = '{16'd60,    16'h0060, 1'b0, {SB, SB, S6, S0}};
    vecs[5] = '{16'd0,     16'h0000, 1'b0, {SB, SB, SB, S0}};
    vecs[6] = '{16'd9999,  16'h9999, 1'b0, {S9, S9, S9, S9}};
    vecs[7] = '{16'd10000, 16'h9999, 1'b1, {S9, S9, S9, S9}};
    vecs[8] = '{16'd508,   16'h0508, 1'b0, {SB, S5, S0, S8}};
    vecs[9] = '{16'd3,     16'h0003, 1'b0, {SB, SB, SB, S3}};

    // Reset state and idle scan sequence with value held at 0
    rst = 1'b1;
    value = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] ea;
      @(negedge clk);
      ea = ~(4'b0001 << (((k - 1) / 4) % 4));
      chk("idle_an", {28'd0, an}, {28'd0, ea});
      chk("idle_seg", {25'd0, seg}, (ea == 4'b1110) ? {25'd0, S0} : {25'd0, SB});
      chk("idle_dp", {31'd0, dp}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Exact conversion latency: 0 -> 72
    value = vecs[0].val;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      chk("lat_busy", {31'd0, busy}, (k <= 18) ? 32'd1 : 32'd0);
      if (k == 18) chk("lat_bcd_old", {16'd0, bcd}, 32'h0000);
      if (k == 19) chk("lat_bcd_new", {16'd0, bcd}, 32'h0072);
    end
    check_frame(vecs[0]);

    // Table of conversions with display frame checks
    for (int i = 1; i < 10; i++) begin
      value = vecs[i].val;
      @(negedge clk);
      @(negedge clk);
      chk("vec_busy_start", {31'd0, busy}, 32'd1);
      wait_not_busy(40);
      chk("vec_bcd", {16'd0, bcd}, {16'd0, vecs[i].bcd});
      chk("vec_ovf", {31'd0, ovf}, {31'd0, vecs[i].ovf});
      @(negedge clk);
      check_frame(vecs[i]);
    end

    // Value changes while busy: 72 finishes, then 96 converts automatically
    value = 16'd72;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k == 5) value = 16'd96;
      if (k == 18) chk("chg_busy18", {31'd0, busy}, 32'd1);
      if (k == 19) begin
        chk("chg_bcd19", {16'd0, bcd}, 32'h0072);
        chk("chg_busy19", {31'd0, busy}, 32'd0);
      end
      if (k == 20) chk("chg_restart", {31'd0, busy}, 32'd1);
      if (k == 37) chk("chg_bcd37", {16'd0, bcd}, 32'h0072);
      if (k == 38) begin
        chk("chg_bcd38", {16'd0, bcd}, 32'h0096);
        chk("chg_busy38", {31'd0, busy}, 32'd0);
      end
    end

    // Reset during SHIFT iteration 8 aborts; conversion restarts afterwards
    value = 16'd65535;
    for (int k = 1; k <= 9; k++) @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_bcd", {16'd0, bcd}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    chk("abort_an", {28'd0, an}, 32'hF);
    chk("abort_seg", {25'd0, seg}, 32'h7F);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_an_first", {28'd0, an}, 32'hE);
    chk("abort_restart", {31'd0, busy}, 32'd1);
    wait_not_busy(40);
    chk("abort_bcd_final", {16'd0, bcd}, 32'h9999);
    chk("abort_ovf_final", {31'd0, ovf}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_bcd_display.md
Name: pulse_bcd_display

Overview:
- Downstream consumer of the 16-bit pulse-rate word (beats per minute) produced by the pulse-counting stage.
- Converts the binary word to four BCD digits with a sequential double-dabble engine.
- Drives a 4-digit common-anode seven-segment display by time-multiplexed scanning, with leading-zero blanking and overflow indication.
- Sits between the pulse-counting stage and the board display pins.

Parameters:
- SCAN_DIV, 250000: clock cycles per digit slot (400 Hz digit rate at 100 MHz; 100 Hz full-frame refresh). Minimum 2.
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show all four digits.

Ports:
- CLK100MHZ  in   1   system clock, 100 MHz, only clock
- rst        in   1   synchronous reset, active-high
- value      in   16  binary pulse rate from upstream, unsigned, may change at any cycle
- busy       out  1   high while a conversion is in progress
- bcd        out  16  last converted result {d3,d2,d1,d0}, d0 = units
- ovf        out  1   last converted value exceeded 9999
- an         out  4   digit enables, active-low, one-hot-zero; an[0] = units
- seg        out  7   segments, active-low, {g,f,e,d,c,b,a}
- dp         out  1   decimal point, active-low

Behaviour:
- One clock (CLK100MHZ); reset synchronous, active-high. Every register updates only on the rising edge of CLK100MHZ.
- Reset values: state=IDLE, busy=0, bcd=16'h0000, ovf=0, last_value=0, scan counter=0, digit index=0, an=4'b1111, seg=7'b1111111, dp=1.
- Conversion FSM:
  - IDLE: if value != last_value, go to LOAD.
  - LOAD: capture raw=value and last_value<=value. If value>9999, load 9999 and set a pending ovf; otherwise load value and clear pending ovf. busy=1.
  - SHIFT: exactly 16 iterations, one per cycle. In each iteration, first add 3 to every BCD nibble that is >=5, then shift {bcd_work, bin} left by 1.
  - DONE: bcd<=bcd_work, ovf<=pending ovf, busy<=0, return to IDLE.
- Latency: mismatch seen in IDLE at cycle N; LOAD at N+1; SHIFT at N+2..N+17; DONE at N+18. New bcd/ovf are visible at N+19. busy is high for cycles N+1..N+18 inclusive.
- Changes to value while busy are ignored. Because last_value holds the loaded value, any difference remaining at IDLE triggers a new conversion automatically. No value is lost except intermediates.
- bcd and ovf hold their value until the next DONE. The display always shows the bcd register, never bcd_work.
- Scanner:
  - The counter counts 0..SCAN_DIV-1. When it wraps, the digit index advances 0→1→2→3→0.
  - an=~(1<<index).
  - The scanner runs independently of the conversion FSM.
  - First enabled digit after reset is index 0 (an=4'b1110), starting the cycle after rst deasserts.
- Segment decode: active-low, 0..9 only, encoded as {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles >9 cannot occur; decode them as blank (1111111).
- Leading-zero blanking (BLANK_LZ=1):
  - d3 blank if d3==0.
  - d2 blank if d3==0 and d2==0.
  - d1 blank if d3, d2 and d1 are all 0.
  - d0 is never blanked. A blanked digit drives seg=1111111.
- dp=0 only when index==3 and ovf=1; otherwise dp=1.
- Reset mid-conversion aborts the conversion: the next cycle shows the reset values. A subsequent nonzero value starts a fresh conversion.
- Width rules: internal shift register is 32 bits (16 BCD + 16 binary). Nibble add-3 never carries across nibbles.

Test Plan (SCAN_DIV=4 in sim):
1. Reset, value=0 → no conversion (busy stays 0). an sequence 1110,1101,1011,0111 with 4 cycles each. seg=1000000 on digit0, 1111111 on digits 1-3. dp=1.
2. value 0→72 at cycle N → busy high N+1..N+18; bcd=16'h0072 at N+19. Digit0 seg=0100100, digit1 seg=1111000, digits 2-3 blank.
3. value=1234 → bcd=16'h1234, ovf=0, no digit blanked. value=1004 → bcd=16'h1004, inner zeros shown (digit1 and digit2 seg=1000000).
4. value=12000 → bcd=16'h9999, ovf=1, dp=0 only while an=0111. Then value=60 → ovf=0, bcd=16'h0060.
5. value=72, then value=96 at cycle N+5 → bcd=16'h0072 at N+19. A second conversion then starts automatically, ending with bcd=16'h0096 by N+39.
6. value=65535 then rst pulsed at SHIFT iteration 8 → next cycle busy=0, bcd=0, an=1111. After release, a conversion restarts and yields bcd=16'h9999, ovf=1.
